// File: rtl/reg_file_sweep_pkg.sv
// Shared encodings for the sweep-cleared register file: write-index select,
// write-data format and the clear-FSM state type.
package reg_file_sweep_pkg;

   localparam logic [1:0] DST_LINK0 = 2'd0;
   localparam logic [1:0] DST_RT    = 2'd1;
   localparam logic [1:0] DST_RD    = 2'd2;
   localparam logic [1:0] DST_LINK3 = 2'd3;

   localparam logic [1:0] MODE_WORD    = 2'd0;
   localparam logic [1:0] MODE_HI16_ZX = 2'd1;
   localparam logic [1:0] MODE_LO16_SX = 2'd2;
   localparam logic [1:0] MODE_LO8_SX  = 2'd3;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

endpackage

// File: rtl/reg_file_wr_fmt.sv
// Write-value formatter: picks pc4 or a reformatted wr_data field.
module reg_file_wr_fmt
   import reg_file_sweep_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         i_wr_src,
   input  logic [1:0]   i_wr_mode,
   input  logic [W-1:0] i_wr_data,
   input  logic [W-1:0] i_pc4,
   output logic [W-1:0] o_wr_val
);

   always_comb begin
      o_wr_val = i_wr_data;
      if (i_wr_src) begin
         o_wr_val = i_pc4;
      end else begin
         // Size casts zero-extend unsigned fields and sign-extend signed ones.
         case (i_wr_mode)
            MODE_HI16_ZX: o_wr_val = W'(i_wr_data[W-1 -: 16]);
            MODE_LO16_SX: o_wr_val = W'($signed(i_wr_data[15:0]));
            MODE_LO8_SX:  o_wr_val = W'($signed(i_wr_data[7:0]));
            default:      o_wr_val = i_wr_data;
         endcase
      end
   end

endmodule

// File: rtl/reg_file_sweep.sv
// Register file cleared by a DEPTH-cycle sweep after reset or clr_req.
// Define REG_FILE_SWEEP_BYPASS_EN to forward a committing write to the read ports.
module reg_file_sweep
   import reg_file_sweep_pkg::*;
#(
   parameter int W        = 32,
   parameter int AW       = 5,
   parameter int LINK_REG = 2**AW-1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req,
   output logic          busy,
   input  logic          wr_en,
   input  logic [1:0]    wr_dst,
   input  logic [AW-1:0] rs,
   input  logic [AW-1:0] rt,
   input  logic [AW-1:0] rd,
   input  logic          wr_src,
   input  logic [1:0]    wr_mode,
   input  logic [W-1:0]  wr_data,
   input  logic [W-1:0]  pc4,
   output logic [W-1:0]  rd_a,
   output logic [W-1:0]  rd_b,
   output logic          wr_drop
);

   localparam int            DEPTH    = 2**AW;
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH-1);
   localparam logic [AW-1:0] LINK_IDX = AW'(LINK_REG);

   state_t          r_state, w_state_nxt;
   logic [AW-1:0]   r_cnt, w_cnt_nxt;
   logic [W-1:0]    r_mem [DEPTH];
   logic [AW-1:0]   w_wr_idx;
   logic [W-1:0]    w_wr_val;
   logic            w_wr_commit;

   reg_file_wr_fmt #(.W(W)) u_wr_fmt (
      .i_wr_src  (wr_src),
      .i_wr_mode (wr_mode),
      .i_wr_data (wr_data),
      .i_pc4     (pc4),
      .o_wr_val  (w_wr_val)
   );

   always_comb begin
      w_wr_idx = LINK_IDX;
      case (wr_dst)
         DST_RT:  w_wr_idx = rt;
         DST_RD:  w_wr_idx = rd;
         default: w_wr_idx = LINK_IDX;
      endcase
   end

   assign busy        = (r_state == CLEAR);
   assign w_wr_commit = wr_en && !busy && (w_wr_idx != '0);
   assign wr_drop     = wr_en && busy && (w_wr_idx != '0);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         IDLE: begin
            if (clr_req) begin
               w_state_nxt = CLEAR;
               w_cnt_nxt   = '0;
            end
         end
         CLEAR: begin
            if (r_cnt == LAST_IDX) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = CLEAR;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Storage has no reset of its own; the sweep is the only clear path.
   always_ff @(posedge clk) begin
      if (busy) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr_commit) begin
         r_mem[w_wr_idx] <= w_wr_val;
      end
   end

   always_comb begin
      rd_a = (rs == '0) ? '0 : r_mem[rs];
      rd_b = (rt == '0) ? '0 : r_mem[rt];
`ifdef REG_FILE_SWEEP_BYPASS_EN
      if (w_wr_commit && (w_wr_idx == rs)) rd_a = w_wr_val;
      if (w_wr_commit && (w_wr_idx == rt)) rd_b = w_wr_val;
`endif
      if (busy) begin
         rd_a = '0;
         rd_b = '0;
      end
   end

endmodule

// File: tb/tb_reg_file_sweep.sv
module tb_reg_file_sweep;

  logic        clk;
  logic        rst;
  logic        clr_req;
  logic        busy;
  logic        wr_en;
  logic [1:0]  wr_dst;
  logic [4:0]  rs, rt, rd;
  logic        wr_src;
  logic [1:0]  wr_mode;
  logic [31:0] wr_data, pc4;
  logic [31:0] rd_a, rd_b;
  logic        wr_drop;

  reg_file_sweep #(.W(32), .AW(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .busy    (busy),
    .wr_en   (wr_en),
    .wr_dst  (wr_dst),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .wr_src  (wr_src),
    .wr_mode (wr_mode),
    .wr_data (wr_data),
    .pc4     (pc4),
    .rd_a    (rd_a),
    .rd_b    (rd_b),
    .wr_drop (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int SEL_RDA  = 0;
  localparam int SEL_RDB  = 1;
  localparam int SEL_BUSY = 2;
  localparam int SEL_DROP = 3;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  chk_t        q[$];
  chk_t        mc;
  logic [31:0] act;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          wait_t;

  task automatic exp_chk(input string nm, input int sel, input logic [31:0] v);
    chk_t c;
    c.name = nm;
    c.sel  = sel;
    c.exp  = v;
    q.push_back(c);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      mc = q.pop_front();
      case (mc.sel)
        SEL_RDA:  act = rd_a;
        SEL_RDB:  act = rd_b;
        SEL_BUSY: act = {31'd0, busy};
        default:  act = {31'd0, wr_drop};
      endcase
      n_chk++;
      if (act === mc.exp) n_pass++;
      else $display("FAIL %s: got %h want %h", mc.name, act, mc.exp);
    end
  end

  logic [31:0] fmt_exp [4];
  logic [31:0] byp_exp;

  initial begin
    fmt_exp[0] = 32'h8001_F0F0;
    fmt_exp[1] = 32'h0000_8001;
    fmt_exp[2] = 32'hFFFF_F0F0;
    fmt_exp[3] = 32'hFFFF_FFF0;
`ifdef REG_FILE_SWEEP_BYPASS_EN
    byp_exp = 32'h0000_1234;
`else
    byp_exp = 32'h0000_AAAA;
`endif
    rst = 1'b1; clr_req = 1'b0; wr_en = 1'b0; wr_dst = 2'd0;
    rs = '0; rt = '0; rd = '0; wr_src = 1'b0; wr_mode = 2'd0;
    wr_data = '0; pc4 = '0;

    cyc();
    n_chk++;
    if (busy === 1'b1 && rd_a === 32'd0 && rd_b === 32'd0 && wr_drop === 1'b0) n_pass++;
    else $display("FAIL reset_state: busy=%b rd_a=%h rd_b=%h wr_drop=%b",
                  busy, rd_a, rd_b, wr_drop);
    rst = 1'b0;
    rs = 5'd4; rt = 5'd6;
    exp_chk("reset_rd_a", SEL_RDA, 32'd0);
    exp_chk("reset_rd_b", SEL_RDB, 32'd0);
    exp_chk("reset_drop", SEL_DROP, 32'd0);
    for (int i = 0; i < 32; i++) begin
      exp_chk("rst_sweep_busy", SEL_BUSY, 32'd1);
      if (i == 20) begin
        wr_en = 1'b1; wr_dst = 2'd2; rd = 5'd3; wr_data = 32'hDEAD_BEEF;
        exp_chk("busy_wr_drop", SEL_DROP, 32'd1);
      end else begin
        wr_en = 1'b0;
      end
      cyc();
    end
    exp_chk("rst_sweep_done", SEL_BUSY, 32'd0);
    for (int r = 0; r < 32; r++) begin
      rs = 5'(r); rt = 5'(31 - r);
      exp_chk("cleared_rd_a", SEL_RDA, 32'd0);
      exp_chk("cleared_rd_b", SEL_RDB, 32'd0);
      cyc();
    end

    for (int m = 0; m < 4; m++) begin
      wr_en = 1'b1; wr_dst = 2'd2; rd = 5'd5; wr_src = 1'b0;
      wr_mode = 2'(m); wr_data = 32'h8001_F0F0;
      cyc();
      wr_en = 1'b0; rs = 5'd5;
      exp_chk("fmt_mode", SEL_RDA, fmt_exp[m]);
      cyc();
    end

    wr_en = 1'b1; wr_dst = 2'd0; wr_src = 1'b1; wr_mode = 2'd3;
    pc4 = 32'h0040_0010; wr_data = 32'hFFFF_FFFF;
    cyc();
    wr_en = 1'b0; rs = 5'd31;
    exp_chk("link_dst0", SEL_RDA, 32'h0040_0010);
    cyc();
    wr_en = 1'b1; wr_dst = 2'd3; pc4 = 32'h0040_0020;
    cyc();
    wr_en = 1'b0; rt = 5'd31;
    exp_chk("link_dst3", SEL_RDB, 32'h0040_0020);
    cyc();

    wr_en = 1'b1; wr_dst = 2'd1; rt = 5'd0; wr_src = 1'b0; wr_mode = 2'd0;
    wr_data = 32'hFFFF_FFFF; rs = 5'd0;
    exp_chk("r0_same_cycle", SEL_RDA, 32'd0);
    exp_chk("r0_no_drop", SEL_DROP, 32'd0);
    cyc();
    wr_en = 1'b0;
    exp_chk("r0_after_a", SEL_RDA, 32'd0);
    exp_chk("r0_after_b", SEL_RDB, 32'd0);
    cyc();

    wr_en = 1'b1; wr_dst = 2'd1; rt = 5'd9; wr_mode = 2'd3; wr_data = 32'h0000_00C3;
    cyc();
    wr_en = 1'b0;
    exp_chk("rt_dst_lo8", SEL_RDB, 32'hFFFF_FFC3);
    cyc();

    wr_en = 1'b1; wr_dst = 2'd2; rd = 5'd7; wr_mode = 2'd0; wr_data = 32'h0000_AAAA;
    cyc();
    wr_data = 32'h0000_1234; rs = 5'd7;
    exp_chk("bypass_same_cycle", SEL_RDA, byp_exp);
    cyc();
    wr_en = 1'b0;
    exp_chk("bypass_after_edge", SEL_RDA, 32'h0000_1234);
    cyc();

    wr_en = 1'b1; wr_dst = 2'd2; rd = 5'd10; wr_data = 32'h0000_0055; clr_req = 1'b1;
    exp_chk("clr_start_idle", SEL_BUSY, 32'd0);
    exp_chk("clr_start_nodrop", SEL_DROP, 32'd0);
    cyc();
    wr_en = 1'b0; clr_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_chk("clr_sweep_busy", SEL_BUSY, 32'd1);
      if (i == 1) begin
        rs = 5'd9;
        exp_chk("busy_read_zero", SEL_RDA, 32'd0);
      end
      clr_req = (i == 5);
      if (i == 4) begin
        wr_en = 1'b1; wr_dst = 2'd1; rt = 5'd12;
        exp_chk("clr_wr_drop", SEL_DROP, 32'd1);
      end else begin
        wr_en = 1'b0;
      end
      cyc();
    end
    rst = 1'b1; clr_req = 1'b0;
    exp_chk("mid_rst_busy", SEL_BUSY, 32'd1);
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      exp_chk("restart_busy", SEL_BUSY, 32'd1);
      cyc();
    end
    rs = 5'd5; rt = 5'd31;
    exp_chk("restart_done", SEL_BUSY, 32'd0);
    exp_chk("restart_r5", SEL_RDA, 32'd0);
    exp_chk("restart_r31", SEL_RDB, 32'd0);
    cyc();

    wr_en = 1'b1; wr_dst = 2'd2; rd = 5'd5; wr_data = 32'h0000_0077;
    cyc();
    wr_en = 1'b0;
    exp_chk("post_sweep_write", SEL_RDA, 32'h0000_0077);
    cyc();
    cyc();

    clr_req = 1'b1;
    cyc();
    clr_req = 1'b0;
    wait_t = 0;
    while (busy === 1'b1 && wait_t < 100) begin
      cyc();
      wait_t++;
    end
    n_chk++;
    if (busy === 1'b0 && wait_t == 32) n_pass++;
    else $display("FAIL sweep_wait: busy=%b after %0d cycles, want 32", busy, wait_t);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_file_sweep.md
REG_FILE_SWEEP -- requirements
Module: reg_file_sweep

Interface
REQ-001 Parameter W, default 32: register data width; legal values are at least 16.
REQ-002 Parameter AW, default 5: index width; the file holds DEPTH = 2**AW registers.
REQ-003 Parameter LINK_REG, default 2**AW-1: link register index; writes target it when wr_dst = 0 or 3.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 clr_req  in  1  requests a full clear sweep.
REQ-007 busy  out  1  high while a clear sweep is in progress.
REQ-008 wr_en  in  1  write request.
REQ-009 wr_dst  in  2  write index select: 0 = LINK_REG, 1 = rt, 2 = rd, 3 = LINK_REG.
REQ-010 rs, rt, rd  in  AW each  register indices.
REQ-011 wr_src  in  1  write source: 0 = formatted wr_data, 1 = pc4.
REQ-012 wr_mode  in  2  wr_data format: 0 = word; 1 = bits [W-1:W-16] zero-extended; 2 = bits [15:0] sign-extended; 3 = bits [7:0] sign-extended.
REQ-013 wr_data, pc4  in  W each  write data candidates.
REQ-014 rd_a, rd_b  out  W each  combinational read of registers[rs] and registers[rt].
REQ-015 wr_drop  out  1  combinational; high when a valid write is discarded because busy is high.

Function
REQ-016 The write index is resolved combinationally from wr_dst, rt and rd.
REQ-017 A write commits on the rising edge when wr_en = 1, busy = 0, and the write index is not 0.
REQ-018 Register 0 always reads 0 and is never written.
REQ-019 wr_mode is ignored when wr_src = 1; pc4 is written unmodified.
REQ-020 Reads are zero-latency combinational: rd_a = registers[rs], rd_b = registers[rt].
REQ-021 The FSM has two states, IDLE and CLEAR, plus a sweep counter of width AW.
REQ-022 In IDLE, clr_req = 1 moves the FSM to CLEAR with counter = 0 on the next edge; busy rises in that cycle.
REQ-023 In CLEAR, each cycle writes 0 to registers[counter] and increments the counter.
REQ-024 CLEAR lasts exactly DEPTH cycles; when counter = DEPTH-1, the FSM returns to IDLE with counter = 0 and busy drops.
REQ-025 clr_req asserted in CLEAR is ignored and does not restart or extend the sweep.
REQ-026 While busy = 1, rd_a and rd_b read 0.
REQ-027 While busy = 1, writes are discarded, and wr_drop = wr_en AND (write index != 0).
REQ-028 If a write and clr_req arrive together in IDLE, the write commits and the sweep starts on the next cycle.

Reset
REQ-029 rst = 1 forces the FSM to CLEAR with counter = 0 on the next edge, including mid-sweep (restart from 0).
REQ-030 After rst deasserts, busy stays high for exactly DEPTH cycles, and then all registers read 0.
REQ-031 Output reset values: busy = 1, rd_a = rd_b = 0, wr_drop = 0.
REQ-032 Register storage has no reset other than the sweep, and there is no initial-block initialisation.

Configuration
REQ-033 Macro REG_FILE_SWEEP_BYPASS_EN, when defined, enables write-to-read bypass.
REQ-034 With the macro defined: when busy = 0 and a committing write targets index rs (or rt), rd_a (or rd_b) shows the formatted write value in the same cycle.
REQ-035 Without the macro, a read of a register being written returns the old value until after the edge.

Structure
REQ-036 Package reg_file_sweep_pkg holds the wr_dst encoding constants, the wr_mode encoding constants, and the FSM state typedef (IDLE, CLEAR).
REQ-037 A combinational sub-module reg_file_wr_fmt maps (wr_src, wr_mode, wr_data, pc4) to the W-bit write value.
REQ-038 The index mux, FSM, storage and bypass live in reg_file_sweep.

Verification
REQ-039 Reset sweep: pulse rst for 1 cycle, then hold clr_req = 0.
- busy is high for exactly 32 cycles.
- Every register then reads 0.
- wr_en with wr_dst = 2, rd = 3 during busy gives wr_drop = 1 and register 3 stays 0.
REQ-040 Write formats: write wr_data = 0x8001_F0F0 to rd = 5 with each wr_mode (0, 1, 2, 3) in turn.
- Mode 0 reads 0x8001F0F0.
- Mode 1 reads 0x00008001.
- Mode 2 reads 0xFFFFF0F0.
- Mode 3 reads 0xFFFFFFF0.
REQ-041 Link and zero:
- wr_dst = 0, wr_src = 1, pc4 = 0x0040_0010: register 31 reads 0x00400010.
- wr_dst = 1 with rt = 0: register 0 still reads 0.
REQ-042 Mid-sweep reset: clr_req, then rst 10 cycles later.
- The sweep restarts from 0.
- busy is high for 10 + 1 + 32 cycles in total.
- clr_req asserted during the sweep changes nothing.
REQ-043 Bypass: write 0x1234 to rd = 7 while rs = 7, with busy = 0.
- With REG_FILE_SWEEP_BYPASS_EN defined, rd_a = 0x1234 in the same cycle.
- Without the macro, rd_a shows the old value until after the edge.
